// File: rtl/ahblite_bram_ctrl_pipe.sv
// AHB-Lite slave onto a simple dual-port 32-bit BRAM with an optional read wait state,
// read-after-write forwarding and two-cycle ERROR responses for illegal accesses.
//
// state     | meaning
// S_IDLE    | ready, address phases accepted, OKAY
// S_RD_WAIT | read wait state for a 2-cycle BRAM, HREADYOUT low
// S_ERR1    | first ERROR cycle, HREADYOUT low
// S_ERR2    | second ERROR cycle, HREADYOUT high, address phases accepted
module ahblite_bram_ctrl_pipe #(
    parameter int ADDR_WIDTH  = 12,
    parameter int REGION_BITS = 16,
    parameter int RD_LATENCY  = 1,
    parameter bit ERR_EN      = 1'b1
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic [3:0]            HPROT,
    input  logic                  HWRITE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic [31:0]           HRDATA,
    output logic                  HRESP,
    output logic [ADDR_WIDTH-1:0] BRAM_RDADDR,
    output logic [ADDR_WIDTH-1:0] BRAM_WRADDR,
    input  logic [31:0]           BRAM_RDATA,
    output logic [31:0]           BRAM_WDATA,
    output logic [3:0]            BRAM_WRITE
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_WAIT = 2'd1,
        S_ERR1    = 2'd2,
        S_ERR2    = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic                  r_wr_pend;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [3:0]            r_wr_lanes;
    logic                  r_rd_pend;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [3:0]            r_fwd_lanes;
    logic [31:0]           r_fwd_data;

    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] w_word_addr;
    logic                  w_out_of_range;
    logic                  w_bad_size;
    logic                  w_misaligned;
    logic                  w_illegal;
    logic [3:0]            w_lanes;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_fwd_hit;
    logic                  w_rd_valid;
    logic [31:0]           w_rd_merged;
    logic                  w_unused;

    assign w_unused = &{1'b0, HPROT, HADDR[31:REGION_BITS], HTRANS[0]};

    assign w_accept       = HSEL & HTRANS[1] & HREADY;
    assign w_word_addr    = HADDR[ADDR_WIDTH+1:2];
    assign w_out_of_range = |HADDR[REGION_BITS-1:ADDR_WIDTH+2];
    assign w_bad_size     = (HSIZE > 3'd2);

    always_comb begin
        w_lanes      = 4'b0000;
        w_misaligned = 1'b0;
        case (HSIZE)
            3'd0: w_lanes = 4'b0001 << HADDR[1:0];
            3'd1: begin
                w_lanes      = HADDR[1] ? 4'b1100 : 4'b0011;
                w_misaligned = HADDR[0];
            end
            3'd2: begin
                w_lanes      = 4'b1111;
                w_misaligned = |HADDR[1:0];
            end
            default: ;
        endcase
    end

    assign w_illegal = w_out_of_range | w_bad_size | w_misaligned;
    assign w_wr_acc  = w_accept &  HWRITE & ~w_illegal;
    assign w_rd_acc  = w_accept & ~HWRITE & ~w_illegal;
    // A read landing on the word currently in its write data phase would see stale BRAM data.
    assign w_fwd_hit = r_wr_pend & (r_wr_addr == w_word_addr);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RD_WAIT: w_state_nxt = S_IDLE;
            S_ERR1:    w_state_nxt = S_ERR2;
            default: begin
                w_state_nxt = S_IDLE;
                if (w_accept && w_illegal && ERR_EN) begin
                    w_state_nxt = S_ERR1;
                end else if (w_rd_acc && (RD_LATENCY == 2)) begin
                    w_state_nxt = S_RD_WAIT;
                end
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state     <= S_IDLE;
            r_wr_pend   <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_lanes  <= 4'b0000;
            r_rd_pend   <= 1'b0;
            r_rd_addr   <= '0;
            r_fwd_lanes <= 4'b0000;
            r_fwd_data  <= 32'h0;
        end else begin
            r_state   <= w_state_nxt;
            r_wr_pend <= w_wr_acc;
            if (w_wr_acc) begin
                r_wr_addr  <= w_word_addr;
                r_wr_lanes <= w_lanes;
            end
            if (HREADY) begin
                r_rd_pend <= w_rd_acc;
                if (w_rd_acc) begin
                    r_rd_addr   <= w_word_addr;
                    r_fwd_lanes <= w_fwd_hit ? r_wr_lanes : 4'b0000;
                    r_fwd_data  <= HWDATA;
                end
            end
        end
    end

    always_comb begin
        w_rd_merged = BRAM_RDATA;
        for (int i = 0; i < 4; i++) begin
            if (r_fwd_lanes[i]) begin
                w_rd_merged[8*i +: 8] = r_fwd_data[8*i +: 8];
            end
        end
    end

    assign w_rd_valid  = r_rd_pend & (r_state != S_RD_WAIT);
    assign HRDATA      = w_rd_valid ? w_rd_merged : 32'h0;
    assign HREADYOUT   = ~((r_state == S_RD_WAIT) | (r_state == S_ERR1));
    assign HRESP       = (r_state == S_ERR1) | (r_state == S_ERR2);
    assign BRAM_RDADDR = (r_state == S_RD_WAIT) ? r_rd_addr : w_word_addr;
    assign BRAM_WRADDR = r_wr_addr;
    assign BRAM_WDATA  = HWDATA;
    assign BRAM_WRITE  = r_wr_pend ? r_wr_lanes : 4'b0000;

endmodule

// File: tb/tb_ahblite_bram_ctrl_pipe.sv
// Directed bench: one bridge with 1-cycle BRAM, one with 2-cycle BRAM, each on a small BRAM model.
module tb_ahblite_bram_ctrl_pipe;
    localparam int AW = 12;

    logic HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    logic        HRESETn;
    logic        HSEL, HWRITE, use2;
    logic [31:0] HADDR, HWDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [3:0]  HPROT;

    logic          sel_a, sel_b;
    logic          rdy_a, resp_a, rdy_b, resp_b;
    logic [31:0]   rdata_a, rdata_b, brd_a, brd_b, bwd_a, bwd_b;
    logic [AW-1:0] rda_a, wra_a, rda_b, wra_b, rq_b;
    logic [3:0]    we_a, we_b;

    logic          rdy, resp;
    logic [31:0]   rdata;
    logic [3:0]    we;
    logic [AW-1:0] wraddr, rdaddr;

    assign sel_a  = HSEL & ~use2;
    assign sel_b  = HSEL & use2;
    assign rdy    = use2 ? rdy_b   : rdy_a;
    assign resp   = use2 ? resp_b  : resp_a;
    assign rdata  = use2 ? rdata_b : rdata_a;
    assign we     = use2 ? we_b    : we_a;
    assign wraddr = use2 ? wra_b   : wra_a;
    assign rdaddr = use2 ? rda_b   : rda_a;

    ahblite_bram_ctrl_pipe #(.ADDR_WIDTH(AW), .REGION_BITS(16), .RD_LATENCY(1), .ERR_EN(1'b1)) dut_a (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(sel_a), .HADDR(HADDR), .HTRANS(HTRANS),
        .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(rdy_a),
        .HREADYOUT(rdy_a), .HRDATA(rdata_a), .HRESP(resp_a), .BRAM_RDADDR(rda_a),
        .BRAM_WRADDR(wra_a), .BRAM_RDATA(brd_a), .BRAM_WDATA(bwd_a), .BRAM_WRITE(we_a));

    ahblite_bram_ctrl_pipe #(.ADDR_WIDTH(AW), .REGION_BITS(16), .RD_LATENCY(2), .ERR_EN(1'b1)) dut_b (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(sel_b), .HADDR(HADDR), .HTRANS(HTRANS),
        .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(rdy_b),
        .HREADYOUT(rdy_b), .HRDATA(rdata_b), .HRESP(resp_b), .BRAM_RDADDR(rda_b),
        .BRAM_WRADDR(wra_b), .BRAM_RDATA(brd_b), .BRAM_WDATA(bwd_b), .BRAM_WRITE(we_b));

    logic [31:0] mem_a [0:(1<<AW)-1];
    logic [31:0] mem_b [0:(1<<AW)-1];

    always @(posedge HCLK) begin
        brd_a <= mem_a[rda_a];
        rq_b  <= rda_b;
        brd_b <= mem_b[rq_b];
        for (int i = 0; i < 4; i++) begin
            if (we_a[i]) mem_a[wra_a][8*i +: 8] <= bwd_a[8*i +: 8];
            if (we_b[i]) mem_b[wra_b][8*i +: 8] <= bwd_b[8*i +: 8];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wd, output logic [31:0] rd, output int waits,
                        output int respc, output logic [3:0] lanes, output logic [AW-1:0] wa);
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HSIZE = size; HWRITE = wr;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = wd;
        waits = 0; respc = 0; lanes = 4'h0; wa = '0; rd = 32'h0;
        for (int n = 0; n < 8; n++) begin
            @(negedge HCLK);
            if (resp) respc++;
            if (we != 4'h0) begin
                lanes = lanes | we;
                wa    = wraddr;
            end
            if (rdy) begin
                rd = rdata;
                break;
            end
            waits++;
        end
    endtask

    task automatic addr_phase(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                              input logic [31:0] wd);
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HSIZE = size; HWRITE = wr; HWDATA = wd;
    endtask

    task automatic bus_idle(input logic [31:0] wd);
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = wd;
    endtask

    typedef struct {
        logic          wr;
        logic [31:0]   addr;
        logic [2:0]    size;
        logic [31:0]   wdata;
        logic [31:0]   exp_rd;
        int            exp_waits;
        int            exp_resp;
        logic [3:0]    exp_lanes;
        logic [AW-1:0] exp_wa;
    } vec_t;

    localparam int NV = 16;
    vec_t vt [NV];

    logic [31:0]   rd;
    int            waits, respc;
    logic [3:0]    lanes;
    logic [AW-1:0] wa;

    initial begin
        vt[0]  = '{1'b1, 32'h0000_0010, 3'd2, 32'hDEAD_BEEF, 32'h0,         0, 0, 4'hF, 12'h004};
        vt[1]  = '{1'b0, 32'h0000_0010, 3'd2, 32'h0,         32'hDEAD_BEEF, 0, 0, 4'h0, 12'h000};
        vt[2]  = '{1'b1, 32'h0000_0020, 3'd2, 32'h1122_3344, 32'h0,         0, 0, 4'hF, 12'h008};
        vt[3]  = '{1'b1, 32'h0000_0021, 3'd0, 32'h0000_AA00, 32'h0,         0, 0, 4'h2, 12'h008};
        vt[4]  = '{1'b0, 32'h0000_0020, 3'd2, 32'h0,         32'h1122_AA44, 0, 0, 4'h0, 12'h000};
        vt[5]  = '{1'b1, 32'h0000_0022, 3'd1, 32'hBEEF_0000, 32'h0,         0, 0, 4'hC, 12'h008};
        vt[6]  = '{1'b0, 32'h0000_0022, 3'd1, 32'h0,         32'hBEEF_AA44, 0, 0, 4'h0, 12'h000};
        vt[7]  = '{1'b1, 32'h0000_4000, 3'd2, 32'h5555_5555, 32'h0,         1, 2, 4'h0, 12'h000};
        vt[8]  = '{1'b0, 32'h0000_0001, 3'd1, 32'h0,         32'h0,         1, 2, 4'h0, 12'h000};
        vt[9]  = '{1'b0, 32'h0000_0000, 3'd3, 32'h0,         32'h0,         1, 2, 4'h0, 12'h000};
        vt[10] = '{1'b1, 32'h0000_0002, 3'd2, 32'h6666_6666, 32'h0,         1, 2, 4'h0, 12'h000};
        vt[11] = '{1'b1, 32'h0000_3FFC, 3'd2, 32'hCAFE_F00D, 32'h0,         0, 0, 4'hF, 12'hFFF};
        vt[12] = '{1'b0, 32'h0000_3FFC, 3'd2, 32'h0,         32'hCAFE_F00D, 0, 0, 4'h0, 12'h000};
        vt[13] = '{1'b1, 32'h0000_8003, 3'd0, 32'h7700_0000, 32'h0,         1, 2, 4'h0, 12'h000};
        vt[14] = '{1'b0, 32'h0000_0013, 3'd0, 32'h0,         32'hDEAD_BEEF, 0, 0, 4'h0, 12'h000};
        vt[15] = '{1'b1, 32'h0000_0006, 3'd1, 32'h1234_0000, 32'h0,         0, 0, 4'hC, 12'h001};

        for (int i = 0; i < (1 << AW); i++) begin
            mem_a[i] = 32'h0;
            mem_b[i] = 32'h0;
        end
        HRESETn = 1'b0; use2 = 1'b0; HSEL = 1'b0; HWRITE = 1'b0; HADDR = 32'h0;
        HWDATA = 32'h0; HTRANS = 2'b00; HSIZE = 3'd0; HPROT = 4'h0;
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        check("rst_ready_a", 32'(rdy_a), 32'h1);
        check("rst_resp_a", 32'(resp_a), 32'h0);
        check("rst_rdata_a", rdata_a, 32'h0);
        check("rst_we_a", 32'(we_a), 32'h0);
        check("rst_ready_b", 32'(rdy_b), 32'h1);
        check("rst_rdata_b", rdata_b, 32'h0);
        HRESETn = 1'b1;

        for (int i = 0; i < NV; i++) begin
            xfer(vt[i].wr, vt[i].addr, vt[i].size, vt[i].wdata, rd, waits, respc, lanes, wa);
            check($sformatf("v%0d_waits", i), 32'(waits), 32'(vt[i].exp_waits));
            check($sformatf("v%0d_resp", i), 32'(respc), 32'(vt[i].exp_resp));
            check($sformatf("v%0d_lanes", i), 32'(lanes), 32'(vt[i].exp_lanes));
            check($sformatf("v%0d_rdata", i), rd, vt[i].exp_rd);
            if (vt[i].exp_lanes != 4'h0) check($sformatf("v%0d_wraddr", i), 32'(wa), 32'(vt[i].exp_wa));
        end

        // Byte write then immediate read of the same word: forwarded lane 3
        xfer(1'b1, 32'h10, 3'd2, 32'h1122_3344, rd, waits, respc, lanes, wa);
        addr_phase(1'b1, 32'h13, 3'd0, 32'h0);
        addr_phase(1'b0, 32'h10, 3'd2, 32'hAA00_0000);
        @(negedge HCLK);
        check("fwd_we", 32'(we), 32'h8);
        check("fwd_wraddr", 32'(wraddr), 32'h4);
        check("fwd_rdaddr", 32'(rdaddr), 32'h4);
        bus_idle(32'h0);
        @(negedge HCLK);
        check("fwd_ready", 32'(rdy), 32'h1);
        check("fwd_rdata", rdata, 32'hAA22_3344);
        xfer(1'b0, 32'h10, 3'd2, 32'h0, rd, waits, respc, lanes, wa);
        check("fwd_mem", rd, 32'hAA22_3344);

        // Two back-to-back byte writes to one word, then a read: merge of BRAM and forwarded bytes
        xfer(1'b1, 32'h14, 3'd2, 32'h0, rd, waits, respc, lanes, wa);
        addr_phase(1'b1, 32'h14, 3'd0, 32'h0);
        addr_phase(1'b1, 32'h15, 3'd0, 32'h0000_0055);
        addr_phase(1'b0, 32'h14, 3'd2, 32'h0000_6600);
        @(negedge HCLK);
        check("merge_we", 32'(we), 32'h2);
        bus_idle(32'h0);
        @(negedge HCLK);
        check("merge_rdata", rdata, 32'h0000_6655);

        // IDLE and BUSY transfers with HSEL high
        addr_phase(1'b1, 32'h10, 3'd2, 32'h0);
        HTRANS = 2'b00;
        @(posedge HCLK); #1;
        HTRANS = 2'b01;
        @(negedge HCLK);
        check("idle_ready", 32'(rdy), 32'h1);
        check("idle_resp", 32'(resp), 32'h0);
        check("idle_we", 32'(we), 32'h0);
        bus_idle(32'h0);
        @(negedge HCLK);
        check("busy_we", 32'(we), 32'h0);
        check("busy_ready", 32'(rdy), 32'h1);

        // Two-cycle BRAM
        use2 = 1'b1;
        xfer(1'b1, 32'h0, 3'd2, 32'hA0A0_A0A0, rd, waits, respc, lanes, wa);
        xfer(1'b1, 32'h4, 3'd2, 32'hB1B1_B1B1, rd, waits, respc, lanes, wa);
        check("lat2_wr_waits", 32'(waits), 32'h0);
        xfer(1'b0, 32'h4, 3'd2, 32'h0, rd, waits, respc, lanes, wa);
        check("lat2_rd_waits", 32'(waits), 32'h1);
        check("lat2_rd_rdata", rd, 32'hB1B1_B1B1);
        addr_phase(1'b0, 32'h0, 3'd2, 32'h0);
        @(posedge HCLK); #1;
        HADDR = 32'h4;
        @(negedge HCLK);
        check("b2b_wait0_ready", 32'(rdy), 32'h0);
        check("b2b_wait0_rdaddr", 32'(rdaddr), 32'h0);
        check("b2b_wait0_rdata", rdata, 32'h0);
        @(posedge HCLK); #1;
        @(negedge HCLK);
        check("b2b_d0_ready", 32'(rdy), 32'h1);
        check("b2b_d0_rdata", rdata, 32'hA0A0_A0A0);
        check("b2b_a1_rdaddr", 32'(rdaddr), 32'h1);
        bus_idle(32'h0);
        @(negedge HCLK);
        check("b2b_wait1_ready", 32'(rdy), 32'h0);
        @(posedge HCLK); #1;
        @(negedge HCLK);
        check("b2b_d1_ready", 32'(rdy), 32'h1);
        check("b2b_d1_rdata", rdata, 32'hB1B1_B1B1);

        // Reset during RD_WAIT
        addr_phase(1'b0, 32'h0, 3'd2, 32'h0);
        bus_idle(32'h0);
        @(negedge HCLK);
        check("rst_rw_pre_ready", 32'(rdy), 32'h0);
        HRESETn = 1'b0; #1;
        check("rst_rw_ready", 32'(rdy), 32'h1);
        check("rst_rw_resp", 32'(resp), 32'h0);
        check("rst_rw_rdata", rdata, 32'h0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        xfer(1'b0, 32'h4, 3'd2, 32'h0, rd, waits, respc, lanes, wa);
        check("rst_rw_next_waits", 32'(waits), 32'h1);
        check("rst_rw_next_rdata", rd, 32'hB1B1_B1B1);

        // Reset during ERR1
        use2 = 1'b0;
        addr_phase(1'b1, 32'h4000, 3'd2, 32'h0);
        bus_idle(32'h0);
        @(negedge HCLK);
        check("rst_err_pre_resp", 32'(resp), 32'h1);
        HRESETn = 1'b0; #1;
        check("rst_err_ready", 32'(rdy), 32'h1);
        check("rst_err_resp", 32'(resp), 32'h0);
        @(negedge HCLK);
        HRESETn = 1'b1;

        // Reset during a write data phase aborts the BRAM write
        addr_phase(1'b1, 32'h30, 3'd2, 32'h0);
        bus_idle(32'h1234_5678);
        @(negedge HCLK);
        check("rst_wr_pre_we", 32'(we), 32'hF);
        HRESETn = 1'b0; #1;
        check("rst_wr_we", 32'(we), 32'h0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        xfer(1'b0, 32'h30, 3'd2, 32'h0, rd, waits, respc, lanes, wa);
        check("rst_wr_aborted", rd, 32'h0);
        check("rst_wr_next_resp", 32'(respc), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
